uart_apb_ctrl: RTL and testbench
================================

Name: uart_apb_ctrl

Overview:
- APB register front-end and sequencer for the UART transmitter/receiver cores; sits between the APB bus (PSEL2 slot) and the tx/rx cores.
- Buffers CPU TX bytes in a small FIFO and launches them one at a time with a start/done handshake.
- Captures received bytes into a holding register with valid/overrun flags, and raises one interrupt line.

Parameters:
- FIFO_DEPTH, 4, TX FIFO entries; power of 2, minimum 2.
- PTR_W, $clog2(FIFO_DEPTH), FIFO pointer width (derived; do not override).

Ports:
- PCLK in 1: single clock.
- PRESET in 1: synchronous active-high reset.
- PSEL in 1: APB select.
- PENABLE in 1: APB access phase.
- PADDR in 8: register address.
- PWRITE in 1: 1 = write.
- PWDATA in 8: write data.
- PRDATA out 8: read data.
- PREADY out 1: transfer complete.
- PSLVERR out 1: transfer error.
- tx_start out 1: one-cycle launch pulse to the transmitter.
- tx_data out 8: byte to transmit; stable from tx_start until tx_done.
- tx_done in 1: one-cycle pulse from the transmitter at the end of the stop bit.
- rx_done in 1: one-cycle pulse from the receiver, byte valid.
- rx_data in 8: received byte, valid when rx_done = 1.
- irq out 1: registered level interrupt.

Behaviour:
Reset:
- PRESET sampled on the PCLK rising edge.
- Reset values: FIFO empty (pointers 0), sequencer IDLE, tx_start=0, tx_data=0, rx_hold=0, rx_valid=0, rx_overrun=0, CTRL=0x03, irq=0.
- Reset mid-byte abandons the byte and flushes the FIFO. Cores share PRESET.

Register map:
- 0x00 TXDATA, W: push to FIFO.
- 0x04 RXDATA, R: returns rx_hold; completed read clears rx_valid.
- 0x08 STATUS, R: [0] rx_valid, [1] rx_overrun, [2] fifo_empty, [3] fifo_full, [4] tx_busy (state != IDLE), [7:5]=0. Write 1 to bit 1 clears overrun; other bits ignored.
- 0x0C CTRL, R/W: [0] tx_en, [1] rx_en, [2] irq_rx_en, [3] irq_txe_en, [4] tx_flush (self-clearing, reads 0), [7:5] reserved, read 0.

APB timing:
- Transfer completes on the cycle PSEL & PENABLE & PREADY.
- Side effects and writes happen only on completion.
- PRDATA is combinational, valid only in the access phase, 0 otherwise.
- PREADY=1 except for a TXDATA write when FIFO is full and tx_en=1: PREADY held 0 until the sequencer pops, then the write completes in the cycle PREADY=1.
- TXDATA write while full and tx_en=0: completes immediately with PSLVERR=1; data dropped.
- Unmapped address: PREADY=1, PSLVERR=1, PRDATA=0, no side effect.
- Writing RXDATA or STATUS bits other than bit 1: no effect, no error.

TX sequencer (states IDLE, START, WAIT, GAP):
- IDLE -> START when tx_en & !fifo_empty. The FIFO head is popped into tx_data on that edge.
- START: tx_start=1 for exactly this cycle -> WAIT.
- WAIT: hold until tx_done -> GAP.
- GAP: one idle cycle -> IDLE. Back-to-back bytes have a 3-cycle controller overhead.
- tx_en cleared mid-byte: the current byte completes; no new START.
- tx_flush: pointers reset the same cycle. A byte already in START/WAIT still completes.
- Push and pop in the same cycle: both occur; count unchanged. Full-with-pop accepts the stalled write that cycle.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are decided by an extra count bit.

RX capture:
- On rx_done & rx_en: rx_hold <= rx_data and rx_valid <= 1.
- If rx_valid was already 1 and is not being cleared this cycle, rx_overrun <= 1 (sticky).
- rx_done and a completed RXDATA read in the same cycle: the new byte wins, rx_valid stays 1, no overrun. The read returns the old byte.
- rx_en=0: rx_done ignored.

Interrupt:
- irq <= (irq_rx_en & rx_valid) | (irq_txe_en & fifo_empty & state==IDLE), registered one cycle.

Decomposition:
- Package uart_pkg holds: register address constants ADDR_TXDATA/RXDATA/STATUS/CTRL; STATUS and CTRL bit-index constants; CTRL reset value 0x03; sequencer state enum (IDLE, START, WAIT, GAP; 2 bits).
- One sub-module, uart_tx_fifo: synchronous FIFO with push/pop/flush, full/empty, parameter FIFO_DEPTH, width 8.
- APB decode, sequencer and RX capture live in uart_apb_ctrl.

Test Plan:
- Reset, then read CTRL, STATUS, RXDATA -> 0x03, 0x04, 0x00. irq=0; tx_start never pulses.
- Write TXDATA 0x55 then 0xA3 -> tx_start pulses with tx_data=0x55. After the tx_done stub (10 cycles later), the second tx_start pulses with tx_data=0xA3 exactly 3 cycles after tx_done.
- Write CTRL=0x02, fill 4 bytes, then a 5th write -> PSLVERR=1, PREADY=1, STATUS[3]=1. Set tx_en and write 5th again -> PREADY=0 until the first pop, then completes. Exactly 5 bytes are transmitted, in order.
- rx_done with 0x3C, then rx_done with 0x7E, no read -> STATUS=0x07 (valid, overrun, empty). RXDATA=0x7E; after the read STATUS=0x06. Write STATUS 0x02 -> STATUS=0x04.
- rx_done 0x11 in the same cycle as a completed RXDATA read of the prior 0x22 -> read returns 0x22, rx_valid=1, overrun=0. Next read returns 0x11.
- Assert PRESET during WAIT with 2 bytes queued -> next cycle state IDLE, fifo_empty=1, tx_start=0. Access to 0x10 -> PSLVERR=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared register map, bit indices and sequencer state encoding for the UART APB controller.
package uart_pkg;

  localparam logic [7:0] ADDR_TXDATA = 8'h00;
  localparam logic [7:0] ADDR_RXDATA = 8'h04;
  localparam logic [7:0] ADDR_STATUS = 8'h08;
  localparam logic [7:0] ADDR_CTRL   = 8'h0C;

  localparam int STAT_RX_VALID   = 0;
  localparam int STAT_RX_OVERRUN = 1;
  localparam int STAT_FIFO_EMPTY = 2;
  localparam int STAT_FIFO_FULL  = 3;
  localparam int STAT_TX_BUSY    = 4;

  localparam int CTRL_TX_EN      = 0;
  localparam int CTRL_RX_EN      = 1;
  localparam int CTRL_IRQ_RX_EN  = 2;
  localparam int CTRL_IRQ_TXE_EN = 3;
  localparam int CTRL_TX_FLUSH   = 4;

  localparam logic [7:0] CTRL_RST = 8'h03;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_apb_ctrl_if.sv
// APB slave bus bundle for the UART controller (PSEL2 slot).
interface uart_apb_ctrl_if;
  logic       PSEL;
  logic       PENABLE;
  logic [7:0] PADDR;
  logic       PWRITE;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;

  modport master (
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the APB TXDATA register and the TX sequencer.
// Latency: head visible combinationally; push/pop/flush take effect on the next edge.
// Backpressure: caller must not push when full unless popping in the same cycle.
module uart_tx_fifo #(
  parameter  int FIFO_DEPTH = 4,
  localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] wr_dat,
  output logic [7:0] rd_dat,
  output logic       full,
  output logic       empty
);

  logic [7:0]   mem [FIFO_DEPTH];
  // One extra pointer bit separates the full and empty cases when the indices match.
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign rd_dat = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/uart_apb_ctrl.sv
// APB register front-end, TX byte sequencer and RX capture for the UART cores.
// Latency: tx_start one cycle after a byte is queued and idle; irq registered one cycle.
// Backpressure: PREADY held low on TXDATA write to a full FIFO while tx_en is set.
module uart_apb_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic           PCLK,
  input  logic           PRESET,
  uart_apb_ctrl_if.slave apb,
  output logic           tx_start,
  output logic [7:0]     tx_data,
  input  logic           tx_done,
  input  logic           rx_done,
  input  logic [7:0]     rx_data,
  output logic           irq
);

  tx_state_t  state;
  tx_state_t  state_nxt;
  logic [3:0] ctrl_q;
  logic [7:0] rx_hold;
  logic       rx_valid;
  logic       rx_overrun;
  logic [7:0] status;

  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_flush;
  logic [7:0] fifo_head;

  logic       access;
  logic       done;
  logic       sel_tx;
  logic       sel_rx;
  logic       sel_st;
  logic       sel_ct;
  logic       mapped;
  logic       tx_en;
  logic       rx_en;
  logic       rd_rx;
  logic       rx_fire;
  logic       clr_overrun;
  logic       unused_pwdata;

  assign tx_en  = ctrl_q[CTRL_TX_EN];
  assign rx_en  = ctrl_q[CTRL_RX_EN];

  assign sel_tx = (apb.PADDR == ADDR_TXDATA);
  assign sel_rx = (apb.PADDR == ADDR_RXDATA);
  assign sel_st = (apb.PADDR == ADDR_STATUS);
  assign sel_ct = (apb.PADDR == ADDR_CTRL);
  assign mapped = sel_tx | sel_rx | sel_st | sel_ct;

  assign access   = apb.PSEL & apb.PENABLE;
  assign fifo_pop = (state == IDLE) & tx_en & ~fifo_empty;

  // A full FIFO stalls the write only while the sequencer can still drain it.
  assign apb.PREADY  = ~(access & apb.PWRITE & sel_tx & fifo_full & tx_en & ~fifo_pop);
  assign done        = access & apb.PREADY;
  assign apb.PSLVERR = access & (~mapped | (apb.PWRITE & sel_tx & fifo_full & ~tx_en));

  assign fifo_push   = done & apb.PWRITE & sel_tx & (~fifo_full | fifo_pop);
  assign fifo_flush  = done & apb.PWRITE & sel_ct & apb.PWDATA[CTRL_TX_FLUSH];
  assign rd_rx       = done & ~apb.PWRITE & sel_rx;
  assign clr_overrun = done & apb.PWRITE & sel_st & apb.PWDATA[STAT_RX_OVERRUN];
  assign rx_fire     = rx_done & rx_en;

  assign unused_pwdata = ^apb.PWDATA[7:5];

  uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk    (PCLK),
    .rst    (PRESET),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .flush  (fifo_flush),
    .wr_dat (apb.PWDATA),
    .rd_dat (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    status                  = '0;
    status[STAT_RX_VALID]   = rx_valid;
    status[STAT_RX_OVERRUN] = rx_overrun;
    status[STAT_FIFO_EMPTY] = fifo_empty;
    status[STAT_FIFO_FULL]  = fifo_full;
    status[STAT_TX_BUSY]    = (state != IDLE);
  end

  always_comb begin
    apb.PRDATA = '0;
    if (access && !apb.PWRITE) begin
      if (sel_rx) apb.PRDATA = rx_hold;
      if (sel_st) apb.PRDATA = status;
      if (sel_ct) apb.PRDATA = {4'b0, ctrl_q};
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (fifo_pop) state_nxt = START;
      START: state_nxt = WAIT;
      WAIT:  if (tx_done) state_nxt = GAP;
      GAP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_start = (state == START);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET)        tx_data <= '0;
    else if (fifo_pop) tx_data <= fifo_head;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET)                               ctrl_q <= CTRL_RST[3:0];
    else if (done && apb.PWRITE && sel_ct)    ctrl_q <= apb.PWDATA[3:0];
  end

  // A byte landing alongside the read that consumes the old one is not an overrun.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rx_hold    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (clr_overrun) rx_overrun <= 1'b0;
      if (rx_fire) begin
        rx_hold  <= rx_data;
        rx_valid <= 1'b1;
        if (rx_valid && !rd_rx) rx_overrun <= 1'b1;
      end else if (rd_rx) begin
        rx_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) irq <= 1'b0;
    else        irq <= (ctrl_q[CTRL_IRQ_RX_EN] & rx_valid) |
                       (ctrl_q[CTRL_IRQ_TXE_EN] & fifo_empty & (state == IDLE));
  end

endmodule

// File: tb/tb_uart_apb_ctrl.sv
// Bench for uart_apb_ctrl: directed register/sequencer scenarios plus a random
// phase scored against a queue-based model of the TX stream and RX holding register.
module tb_uart_apb_ctrl;
  import uart_pkg::*;

  logic       PCLK;
  logic       PRESET;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       irq;

  uart_apb_ctrl_if bus ();

  uart_apb_ctrl #(.FIFO_DEPTH(4)) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .apb      (bus),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .rx_done  (rx_done),
    .rx_data  (rx_data),
    .irq      (irq)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  // model state
  logic [7:0] exp_q[$];
  logic [7:0] sent_q[$];
  int         start_cyc[$];
  int         done_cyc[$];
  int         n_start = 0;
  logic       m_valid, m_over;
  logic [7:0] m_hold, m_ctrl;

  // transmitter stub
  int         tx_lat    = 10;
  int         stub_cnt  = 0;
  bit         stub_busy = 0;
  logic [7:0] stub_byte;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge PCLK);
      if (PRESET) begin
        stub_busy = 0;
        tx_done   = 1'b0;
      end else begin
        tx_done = 1'b0;
        if (tx_start) begin
          sent_q.push_back(tx_data);
          start_cyc.push_back(cyc);
          n_start++;
          stub_busy = 1;
          stub_byte = tx_data;
          stub_cnt  = tx_lat;
        end else if (stub_busy) begin
          stub_cnt--;
          if (stub_cnt == 0) begin
            chk("tx_data_hold", tx_data, stub_byte);
            tx_done   = 1'b1;
            done_cyc.push_back(cyc);
            stub_busy = 0;
          end
        end
      end
    end
  end

  task automatic apb_xfer(input logic [7:0] a, input logic w, input logic [7:0] wd,
                          output logic [7:0] rd, output logic err, output int stalls);
    @(posedge PCLK); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PADDR = a; bus.PWRITE = w; bus.PWDATA = wd;
    if (!w) begin
      @(negedge PCLK);
      chk("prdata_setup", bus.PRDATA, 8'h00);
    end
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    stalls = 0;
    @(negedge PCLK);
    while (!bus.PREADY && stalls < 200) begin
      stalls++;
      @(negedge PCLK);
    end
    if (stalls >= 200) chk("apb_timeout", bus.PREADY, 1'b1);
    rd  = bus.PRDATA;
    err = bus.PSLVERR;
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic exp_err);
    logic [7:0] v; logic e; int s;
    apb_xfer(a, 1'b1, d, v, e, s);
    chk("wr_err", e, exp_err);
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string tag);
    logic [7:0] v; logic e; int s;
    apb_xfer(a, 1'b0, 8'h00, v, e, s);
    chk(tag, v, exp);
  endtask

  task automatic wr_tx(input logic [7:0] d);
    wr(ADDR_TXDATA, d, 1'b0);
    exp_q.push_back(d);
  endtask

  task automatic rx_byte(input logic [7:0] d);
    @(posedge PCLK); #1;
    rx_done = 1'b1; rx_data = d;
    @(posedge PCLK); #1;
    rx_done = 1'b0;
    if (m_ctrl[CTRL_RX_EN]) begin
      if (m_valid) m_over = 1'b1;
      m_hold  = d;
      m_valid = 1'b1;
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    repeat (n) @(posedge PCLK);
    #1 PRESET = 1'b0;
    m_valid = 0; m_over = 0; m_hold = 8'h00; m_ctrl = CTRL_RST;
    exp_q.delete(); sent_q.delete(); start_cyc.delete(); done_cyc.delete();
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((sent_q.size() < exp_q.size() || stub_busy) && k < 3000) begin
      @(negedge PCLK);
      k++;
    end
    chk({tag, "_cnt"}, sent_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++)
      chk({tag, "_byte"}, sent_q[i], exp_q[i]);
    sent_q.delete(); exp_q.delete();
    repeat (4) @(posedge PCLK);
  endtask

  task automatic irq_chk(input logic exp, input string tag);
    @(posedge PCLK); @(negedge PCLK);
    chk(tag, irq, exp);
  endtask

  logic [7:0] rv, d8, c8;
  logic       re;
  int         rs, n0, k0;

  initial begin
    PRESET = 1'b1; rx_done = 1'b0; rx_data = 8'h00;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PADDR = 8'h00; bus.PWRITE = 1'b0; bus.PWDATA = 8'h00;
    do_reset(3);

    // reset values
    rd(ADDR_CTRL,   8'h03, "rst_ctrl");
    rd(ADDR_STATUS, 8'h04, "rst_status");
    rd(ADDR_RXDATA, 8'h00, "rst_rxdata");
    chk("rst_irq", irq, 1'b0);
    chk("rst_no_start", n_start, 0);

    // back-to-back launch and 3-cycle gap
    start_cyc.delete(); done_cyc.delete();
    wr_tx(8'h55);
    wr_tx(8'hA3);
    drain("b2b");
    chk("b2b_gap", start_cyc[1] - done_cyc[0], 3);

    // full FIFO: drop with tx_en=0, stall with tx_en=1
    tx_lat = 60;
    wr_tx(8'h10);
    wr(ADDR_CTRL, 8'h02, 1'b0);
    for (int i = 1; i <= 4; i++) wr_tx(8'h10 + 8'(i));
    rd(ADDR_STATUS, 8'h18, "full_status");
    apb_xfer(ADDR_TXDATA, 1'b1, 8'h15, rv, re, rs);
    chk("full_drop_err", re, 1'b1);
    chk("full_drop_rdy", rs, 0);
    wr(ADDR_CTRL, 8'h03, 1'b0);
    apb_xfer(ADDR_TXDATA, 1'b1, 8'h15, rv, re, rs);
    chk("full_stall_err", re, 1'b0);
    chk("full_stall_seen", rs > 0, 1'b1);
    exp_q.push_back(8'h15);
    drain("full");
    tx_lat = 10;

    // flush
    wr(ADDR_CTRL, 8'h02, 1'b0);
    wr(ADDR_TXDATA, 8'h61, 1'b0);
    wr(ADDR_TXDATA, 8'h62, 1'b0);
    rd(ADDR_STATUS, 8'h00, "pre_flush_status");
    wr(ADDR_CTRL, 8'h12, 1'b0);
    rd(ADDR_CTRL,   8'h02, "flush_ctrl");
    rd(ADDR_STATUS, 8'h04, "flush_status");
    n0 = n_start;
    wr(ADDR_CTRL, 8'h03, 1'b0);
    repeat (20) @(posedge PCLK);
    chk("flush_no_start", n_start, n0);

    // RX overrun and clear
    m_ctrl = 8'h03;
    rx_byte(8'h3C);
    rx_byte(8'h7E);
    rd(ADDR_STATUS, 8'h07, "ovr_status");
    rd(ADDR_RXDATA, 8'h7E, "ovr_rxdata");
    rd(ADDR_STATUS, 8'h06, "ovr_status_rd");
    wr(ADDR_STATUS, 8'h02, 1'b0);
    rd(ADDR_STATUS, 8'h04, "ovr_status_clr");
    wr(ADDR_RXDATA, 8'hFF, 1'b0);
    rd(ADDR_STATUS, 8'h04, "rxdata_wr_noeffect");

    // byte arrives in the same cycle as the read of the previous one
    rx_byte(8'h22);
    fork
      apb_xfer(ADDR_RXDATA, 1'b0, 8'h00, rv, re, rs);
      begin
        @(posedge PCLK); @(posedge PCLK); #1;
        rx_done = 1'b1; rx_data = 8'h11;
        @(posedge PCLK); #1;
        rx_done = 1'b0;
      end
    join
    chk("same_cyc_old", rv, 8'h22);
    rd(ADDR_STATUS, 8'h05, "same_cyc_status");
    rd(ADDR_RXDATA, 8'h11, "same_cyc_new");

    // rx_en=0 ignores rx_done
    wr(ADDR_CTRL, 8'h01, 1'b0);
    m_ctrl = 8'h01;
    rx_byte(8'h99);
    rd(ADDR_STATUS, 8'h04, "rx_dis_status");

    // interrupt sources
    wr(ADDR_CTRL, 8'h07, 1'b0);
    m_ctrl = 8'h07;
    rx_byte(8'h5A);
    irq_chk(1'b1, "irq_rx_set");
    rd(ADDR_RXDATA, 8'h5A, "irq_rx_data");
    irq_chk(1'b0, "irq_rx_clr");
    wr(ADDR_CTRL, 8'h0B, 1'b0);
    irq_chk(1'b1, "irq_txe_set");
    wr(ADDR_CTRL, 8'h03, 1'b0);
    irq_chk(1'b0, "irq_txe_clr");

    // random phase
    do_reset(2);
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0: begin
          d8 = 8'($urandom);
          wr_tx(d8);
        end
        1: rx_byte(8'($urandom));
        2: begin
          rd(ADDR_RXDATA, m_hold, "rnd_rxdata");
          m_valid = 1'b0;
        end
        3: begin
          apb_xfer(ADDR_STATUS, 1'b0, 8'h00, rv, re, rs);
          chk("rnd_status", rv & 8'h03, {6'b0, m_over, m_valid});
        end
        4: begin
          c8 = 8'h01;
          c8[CTRL_RX_EN]     = ($urandom_range(0, 3) != 0);
          c8[CTRL_IRQ_RX_EN] = 1'($urandom_range(0, 1));
          wr(ADDR_CTRL, c8, 1'b0);
          m_ctrl = c8;
        end
        default: begin
          d8 = 8'($urandom);
          wr(ADDR_STATUS, d8, 1'b0);
          if (d8[STAT_RX_OVERRUN]) m_over = 1'b0;
        end
      endcase
      irq_chk(m_ctrl[CTRL_IRQ_RX_EN] & m_valid, "rnd_irq");
    end
    drain("rnd_tx");

    // reset while a byte is in flight with two queued
    do_reset(2);
    wr_tx(8'hA1);
    wr_tx(8'hA2);
    wr_tx(8'hA3);
    chk("mid_rst_busy", stub_busy, 1'b1);
    @(posedge PCLK); #1 PRESET = 1'b1;
    @(posedge PCLK); #1 PRESET = 1'b0;
    @(negedge PCLK);
    chk("mid_rst_tx_start", tx_start, 1'b0);
    n0 = n_start;
    rd(ADDR_STATUS, 8'h04, "mid_rst_status");
    rd(ADDR_CTRL,   8'h03, "mid_rst_ctrl");
    k0 = 0;
    repeat (30) begin
      @(negedge PCLK);
      if (tx_done) k0++;
    end
    chk("mid_rst_no_start", n_start, n0);
    chk("mid_rst_no_done", k0, 0);
    exp_q.delete(); sent_q.delete();

    // unmapped accesses
    apb_xfer(8'h10, 1'b1, 8'hFF, rv, re, rs);
    chk("unmapped_wr_err", re, 1'b1);
    apb_xfer(8'h10, 1'b0, 8'h00, rv, re, rs);
    chk("unmapped_rd_err", re, 1'b1);
    chk("unmapped_rd_data", rv, 8'h00);
    apb_xfer(8'h03, 1'b0, 8'h00, rv, re, rs);
    chk("misaligned_err", re, 1'b1);
    rd(ADDR_CTRL, 8'h03, "unmapped_noeffect");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
